// File: rtl/lut_unit.sv
`default_nettype none
// ============================================================================
// Module   : lut_unit
// Purpose  : Serially reloadable N_IN-input lookup table. Loads go into a
//            shadow table and are swapped in atomically on the final bit.
// Revision : 1.0 - initial release
// ============================================================================
module lut_unit #(
  parameter int N_IN = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_sel,
  output logic            out_valid,
  output logic            out
);

  localparam int            DEPTH      = 2**N_IN;
  localparam logic [N_IN:0] c_LAST_IDX = (N_IN+1)'(DEPTH-1);
  localparam logic [N_IN:0] c_IDX_ONE  = (N_IN+1)'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N_IN:0]    idx_q, idx_d;
  logic [DEPTH-1:0] shadow_q, shadow_d;
  logic [DEPTH-1:0] active_q, active_d;
  logic             table_valid_q, table_valid_d;
  logic             cfg_done_q, cfg_done_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic [DEPTH-1:0] w_shadow_wr;
  logic             w_accept;
  logic             w_last;

  assign cfg_ready = (state_q == LOAD);
  // A start in the same cycle as a valid bit wins; that bit is dropped.
  assign w_accept  = cfg_valid & cfg_ready & ~cfg_start;
  assign w_last    = w_accept & (idx_q == c_LAST_IDX);

  always_comb begin
    w_shadow_wr = shadow_q;
    w_shadow_wr[idx_q[N_IN-1:0]] = cfg_bit;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    table_valid_d = table_valid_q;
    cfg_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d  = LOAD;
          idx_d    = '0;
          shadow_d = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          idx_d    = '0;
          shadow_d = '0;
        end else if (w_accept) begin
          shadow_d = w_shadow_wr;
          idx_d    = idx_q + c_IDX_ONE;
          if (w_last) begin
            // Final bit goes straight into the active copy on the same edge.
            active_d      = w_shadow_wr;
            table_valid_d = 1'b1;
            cfg_done_d    = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lookups read the registered table, so a same-edge swap is not yet visible.
  always_comb begin
    out_d       = out_q;
    out_valid_d = in_valid & table_valid_q;
    if (out_valid_d) begin
      out_d = active_q[in_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      table_valid_q <= 1'b0;
      cfg_done_q    <= 1'b0;
      out_q         <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      table_valid_q <= table_valid_d;
      cfg_done_q    <= cfg_done_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign cfg_done  = cfg_done_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_unit
// Purpose  : Directed bench for lut_unit at N_IN=2 and N_IN=4 with a
//            table-level reference model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs[2], cv[2], cb[2], iv[2];
  logic [3:0] isel[2];
  logic       rdy[2], done[2], ov[2], o[2];

  int n_cmp = 0;
  int n_bad = 0;
  int dcnt[2];

  always #5 clk = ~clk;

  lut_unit #(.N_IN(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .cfg_start(cs[0]), .cfg_valid(cv[0]), .cfg_bit(cb[0]),
    .cfg_ready(rdy[0]), .cfg_done(done[0]),
    .in_valid(iv[0]), .in_sel(isel[0][1:0]),
    .out_valid(ov[0]), .out(o[0])
  );

  lut_unit #(.N_IN(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .cfg_start(cs[1]), .cfg_valid(cv[1]), .cfg_bit(cb[1]),
    .cfg_ready(rdy[1]), .cfg_done(done[1]),
    .in_valid(iv[1]), .in_sel(isel[1]),
    .out_valid(ov[1]), .out(o[1])
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: a table is a list of bits gathered since the last start.
  int   depth[2] = '{4, 16};
  logic m_act[2][16];
  logic m_buf[2][16];
  int   m_fill[2];
  logic m_tv[2], m_load[2];
  logic e_out[2], e_ov[2], e_done[2];
  logic s_rst;
  logic s_cs[2], s_cv[2], s_cb[2], s_iv[2];
  int   s_sel[2];
  bit   seen_rst = 1'b0;

  task automatic model_reset(input int k);
    for (int i = 0; i < 16; i++) begin
      m_act[k][i] = 1'b0;
      m_buf[k][i] = 1'b0;
    end
    m_fill[k] = 0;
    m_tv[k]   = 1'b0;
    m_load[k] = 1'b0;
    e_out[k]  = 1'b0;
    e_ov[k]   = 1'b0;
    e_done[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    e_done[k] = 1'b0;
    e_ov[k]   = s_iv[k] && m_tv[k];
    if (e_ov[k]) e_out[k] = m_act[k][s_sel[k]];
    if (s_cs[k]) begin
      m_load[k] = 1'b1;
      m_fill[k] = 0;
    end else if (m_load[k] && s_cv[k]) begin
      m_buf[k][m_fill[k]] = s_cb[k];
      m_fill[k]++;
      if (m_fill[k] == depth[k]) begin
        for (int i = 0; i < 16; i++) m_act[k][i] = m_buf[k][i];
        m_tv[k]   = 1'b1;
        m_load[k] = 1'b0;
        e_done[k] = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      s_rst = rst;
      for (int k = 0; k < 2; k++) begin
        s_cs[k]  = cs[k];
        s_cv[k]  = cv[k];
        s_cb[k]  = cb[k];
        s_iv[k]  = iv[k];
        s_sel[k] = int'(isel[k]) % depth[k];
      end
      #1;
      if (s_rst) begin
        seen_rst = 1'b1;
        for (int k = 0; k < 2; k++) model_reset(k);
      end else if (seen_rst) begin
        for (int k = 0; k < 2; k++) model_step(k);
      end
      if (seen_rst) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("u%0d cfg_ready", k), rdy[k], m_load[k]);
          chk($sformatf("u%0d cfg_done", k), done[k], e_done[k]);
          chk($sformatf("u%0d out_valid", k), ov[k], e_ov[k]);
          chk($sformatf("u%0d out", k), o[k], e_out[k]);
        end
      end
    end
  end

  initial begin
    dcnt[0] = 0;
    dcnt[1] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) if (done[k] === 1'b1) dcnt[k]++;
    end
  end

  task automatic drv(input int k, input logic s, input logic v, input logic b,
                     input logic ivl, input logic [3:0] sel);
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      cs[j] = 1'b0; cv[j] = 1'b0; cb[j] = 1'b0; iv[j] = 1'b0; isel[j] = 4'd0;
    end
    cs[k] = s; cv[k] = v; cb[k] = b; iv[k] = ivl; isel[k] = sel;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic look(input int k, input logic [3:0] sel, input logic expb);
    drv(k, 1'b0, 1'b0, 1'b0, 1'b1, sel);
    settle();
    chk($sformatf("u%0d lookup sel=%0d valid", k, sel), ov[k], 1'b1);
    chk($sformatf("u%0d lookup sel=%0d out", k, sel), o[k], expb);
  endtask

  task automatic load(input int k, input logic [15:0] tbl);
    drv(k, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < depth[k]; i++) drv(k, 1'b0, 1'b1, tbl[i], 1'b0, 4'd0);
    settle();
    chk($sformatf("u%0d done after last bit", k), done[k], 1'b1);
  endtask

  logic [3:0]  and_t  = 4'b1000;
  logic [3:0]  xor_o  = 4'b0110;
  logic [15:0] big_t  = 16'hA5C3;
  logic [6:0]  swap_o = 7'b0011111;

  initial begin
    for (int j = 0; j < 2; j++) begin
      cs[j] = 1'b0; cv[j] = 1'b0; cb[j] = 1'b0; iv[j] = 1'b0; isel[j] = 4'd0;
    end
    rst = 1'b1;
    settle();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d reset cfg_ready", k), rdy[k], 1'b0);
      chk($sformatf("u%0d reset cfg_done", k), done[k], 1'b0);
      chk($sformatf("u%0d reset out_valid", k), ov[k], 1'b0);
      chk($sformatf("u%0d reset out", k), o[k], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Stray config bits while idle are ignored.
    drv(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    drv(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    settle();
    chk("u0 idle valid keeps ready low", rdy[0], 1'b0);

    // No table loaded: lookups never report valid.
    for (int c = 0; c < 10; c++) begin
      drv(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
      settle();
      chk("u0 no-table out_valid", ov[0], 1'b0);
      chk("u0 no-table out", o[0], 1'b0);
    end

    // AND table.
    load(0, 16'h0008);
    for (int s = 0; s < 4; s++) look(0, 4'(s), and_t[s]);
    chk_int("u0 done count after AND", dcnt[0], 1);

    // XOR load with continuous lookups of index 3 across the swap.
    drv(0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
    settle();
    chk("u0 swap seq 0", o[0], swap_o[0]);
    for (int i = 0; i < 4; i++) begin
      drv(0, 1'b0, 1'b1, xor_o[i], 1'b1, 4'd3);
      settle();
      chk($sformatf("u0 swap seq %0d", i + 1), o[0], swap_o[i + 1]);
    end
    for (int i = 5; i < 7; i++) begin
      drv(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
      settle();
      chk($sformatf("u0 swap seq %0d", i), o[0], swap_o[i]);
    end
    chk_int("u0 done count after XOR", dcnt[0], 2);

    // Restart mid-load; the restarting cycle also carries a bit that is dropped.
    drv(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    drv(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    drv(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    drv(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) drv(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    settle();
    chk("u0 restart done", done[0], 1'b1);
    for (int s = 0; s < 4; s++) look(0, 4'(s), 1'b1);
    chk_int("u0 done count after restart", dcnt[0], 3);

    // Reset after three of four bits, with the fourth bit offered on the reset edge.
    drv(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) drv(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    drv(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    rst = 1'b1;
    settle();
    chk("u0 mid-load rst cfg_ready", rdy[0], 1'b0);
    chk("u0 mid-load rst cfg_done", done[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drv(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    settle();
    chk("u0 post-rst table invalid", ov[0], 1'b0);
    drv(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    settle();
    chk("u0 post-rst not loading", rdy[0], 1'b0);
    chk_int("u0 no done from aborted load", dcnt[0], 3);
    load(0, 16'h0006);
    for (int s = 0; s < 4; s++) look(0, 4'(s), xor_o[s]);
    chk_int("u0 done count after reload", dcnt[0], 4);

    // Four-input table sweep.
    load(1, big_t);
    for (int s = 0; s < 16; s++) look(1, 4'(s), big_t[s]);
    chk_int("u1 done count", dcnt[1], 1);

    drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    settle();
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/lut_unit.md
LUT_UNIT -- requirements
Module: lut_unit

Interface
REQ-001 Parameter N_IN, default 2, number of select inputs; legal range 1..6.
REQ-002 Parameter DEPTH, fixed at 2**N_IN and not overridable; function table size in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cfg_start  input  1  begins a new table load.
REQ-006 cfg_valid  input  1  cfg_bit is valid this cycle.
REQ-007 cfg_bit  input  1  serial table bit, entry 0 first.
REQ-008 cfg_ready  output  1  block accepts cfg_bit this cycle.
REQ-009 cfg_done  output  1  one-cycle pulse: new table now active.
REQ-010 in_valid  input  1  lookup request this cycle.
REQ-011 in_sel  input  N_IN  lookup index; in_sel[N_IN-1] is MSB.
REQ-012 out_valid  output  1  out carries a fresh lookup result.
REQ-013 out  output  1  registered result, equal to active_table[in_sel].

Function
REQ-014 The block SHALL hold two DEPTH-bit registers: active_table, used for lookups, and shadow_table, used for loading.
REQ-015 The block SHALL hold a table_valid flag, set on the first completed load and cleared only by rst.
REQ-016 The FSM SHALL have states IDLE and LOAD.
  - IDLE -> LOAD on cfg_start.
  - LOAD -> IDLE on acceptance of the final bit.
REQ-017 cfg_ready SHALL be 1 exactly when the state is LOAD.
REQ-018 A bit SHALL be accepted when cfg_valid=1 and cfg_ready=1 and cfg_start=0.
  - The bit is written to shadow_table[idx], then idx increments.
  - idx is N_IN+1 bits wide and is cleared on entry to LOAD.
REQ-019 On acceptance of bit idx=DEPTH-1, the block SHALL, in the same edge:
  - copy shadow_table, including the final bit, into active_table;
  - set table_valid;
  - return to IDLE.
REQ-020 cfg_done SHALL be 1 for exactly the cycle after the final-bit edge.
REQ-021 cfg_start asserted in LOAD SHALL restart the load: idx=0, partial shadow contents discarded, state stays LOAD.
REQ-022 cfg_start asserted with cfg_valid=1 SHALL discard that cfg_bit (start wins).
REQ-023 cfg_valid with cfg_ready=0 SHALL be ignored without error.
REQ-024 A lookup SHALL occur when in_valid=1 and table_valid=1, in either FSM state.
  - The lookup registers out <= active_table[in_sel] and out_valid <= 1.
  - Latency is exactly one cycle.
REQ-025 A lookup in the same cycle as a table swap SHALL use the old active_table; the new table applies from the next cycle.
REQ-026 When in_valid=0 or table_valid=0, out_valid SHALL be 0 next cycle and out SHALL hold its previous value.
REQ-027 Lookups SHALL be accepted every cycle (full throughput); no backpressure exists on the lookup path.
REQ-028 All outputs SHALL be driven from registers except cfg_ready, which decodes the state register.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL set:
  - state=IDLE, idx=0;
  - active_table=0, shadow_table=0;
  - table_valid=0;
  - out=0, out_valid=0, cfg_done=0.
REQ-030 rst SHALL take priority over every other input, including mid-load; a load interrupted by rst is lost and must be restarted with cfg_start.
REQ-031 After rst, lookups SHALL produce out_valid=0 until the first load completes.

Verification
REQ-032 N_IN=2:
  - Stimulus: rst, then cfg_start, then bits 0,0,0,1 (AND table, 4'b1000), then in_sel=00,01,10,11 with in_valid=1.
  - Response: cfg_done pulses once, one cycle after bit 3; out=0,0,0,1, each one cycle later with out_valid=1.
REQ-033 N_IN=2 with AND table loaded:
  - Stimulus: cfg_start, bits 0,1,1,0 (XOR) with in_valid=1, in_sel=11 held every cycle.
  - Response: out=1 through the swap cycle; out=0 starting the cycle after the swap.
REQ-034 Stimulus: cfg_start, two bits, cfg_start again, then four bits 1,1,1,1.
  - Response: active_table=4'b1111; exactly one cfg_done pulse.
REQ-035 Stimulus: rst, then in_valid=1 with no load.
  - Response: out_valid=0 and out=0 for 10 cycles.
REQ-036 Stimulus: rst asserted after 3 of 4 bits loaded.
  - Response: cfg_ready=0, table_valid=0, no cfg_done pulse.
  - Follow-up: a new full load of 4'b0110 then works correctly.
REQ-037 N_IN=4:
  - Stimulus: load 16'hA5C3, then sweep in_sel 0..15.
  - Response: out matches bit in_sel of 16'hA5C3 each cycle, one cycle after its in_sel.
